mips_control_unit: RTL and testbench
====================================

Name: mips_control_unit

Overview:
- Main decoder of the reduced-MIPS 5-stage pipeline; sits in the ID stage.
- Decodes opcode and func into per-stage control bundles (ID, EXE, MEM, WRB).
- Bundles are registered into the ID/EX boundary with one cycle of latency.
- An illegal opcode produces a bubble (all-zero controls) and raises a flag.

Parameters:
- NB_OPCODE, 6, opcode width
- NB_FUNC, 6, R-type func width
- NB_ID_CTRL, 6, ID/jump control width
- NB_EXE_CTRL, 4, EXE control width
- NB_MEM_CTRL, 6, MEM control width
- NB_WRB_CTRL, 2, write-back control width

Ports:
- i_clock  in  1  pipeline clock; all state updates on the rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_valid  in  1  instruction in ID is valid; 0 loads a bubble
- i_flush  in  1  forces a bubble; has priority over i_valid
- i_opcode  in  NB_OPCODE  instr[31:26]
- i_func  in  NB_FUNC  instr[5:0]
- o_id_ctrl  out  NB_ID_CTRL  [5] link, [4] reg_dst_rd, [3] beq, [2] bne, [1] jump_imm, [0] jump_reg
- o_exe_ctrl  out  NB_EXE_CTRL  [3] alu_src_imm, [2:0] alu_op
- o_mem_ctrl  out  NB_MEM_CTRL  [5] mem_write, [4] mem_read, [3] unsigned, [2:1] size (00 byte, 01 half, 11 word), [0] reserved (0)
- o_wrb_ctrl  out  NB_WRB_CTRL  [1] reg_write, [0] mem_to_reg
- o_illegal  out  1  registered illegal-opcode flag

Behaviour:
- Reset: while i_reset is high, all outputs are 0 asynchronously (a NOP bubble).
- Latency: outputs reflect the inputs sampled at the previous rising edge; there is no handshake.
- Bubble: when i_flush=1 or i_valid=0, the next state is all-zero and o_illegal=0.
- alu_op encoding:
  - 000 FUNC: the ALU decodes func
  - 001 ADD, 010 AND, 011 OR, 100 XOR, 101 LUI, 110 SLT, 111 SUB
- R-type (opcode 000000):
  - Default: exe=0000, reg_dst_rd=1, wrb=10, mem=0.
  - func 001000 (JR): jump_reg=1; reg_write=0; exe=0000.
  - func 001001 (JALR): jump_reg=1, link=1, reg_dst_rd=1, reg_write=1.
  - Any other func (including 000000 and 101010) follows the R-type default.
- J (000010): jump_imm=1; all other fields 0.
- JAL (000011): jump_imm=1, link=1, reg_dst_rd=0 (destination $31), wrb=10.
- BEQ (000100): beq=1, exe=0111. BNE (000101): bne=1, exe=0111. Neither writes a register.
- Immediate ALU instructions (alu_src_imm=1, wrb=10, destination rt):
  - ADDI 001000 -> 1001
  - SLTI 001010 -> 1110
  - ANDI 001100 -> 1010
  - ORI 001101 -> 1011
  - XORI 001110 -> 1100
  - LUI 001111 -> 1101
- Loads (exe=1001, mem_read=1, wrb=11):
  - LB 100000: size 00, signed
  - LH 100001: size 01, signed
  - LW 100011: size 11, signed
  - LBU 100100: size 00, unsigned
  - LHU 100101: size 01, unsigned
  - LWU 100111: size 11, unsigned
- Stores (exe=1001, mem_write=1, wrb=00):
  - SB 101000: size 00
  - SH 101001: size 01
  - SW 101011: size 11
- Any other opcode: all control fields 0 and o_illegal=1 on the next cycle.
- Structure:
  - Decode is pure combinational, with full default assignment and no latches.
  - A single register stage follows, updated every edge (no hold).
  - Destination register: if link=1 and reg_dst_rd=0, the destination is $31.
- Reset mid-operation: outputs clear immediately; the first post-reset edge loads the current decoded inputs.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode and func localparams
  - alu_op codes and mem size codes
  - bit-index constants for every bundle field
  - the NOP bundle constant
- One natural sub-module, mips_main_decoder: the combinational opcode/func-to-bundle map.
- The top level adds the flush/valid mux and the async-reset register.

Test Plan:
- Reset asserted mid-cycle -> all outputs are 0 immediately. Release reset, then opcode=000000, func=000000, valid=1 -> after 1 edge: id=010000, exe=0000, mem=000000, wrb=10, illegal=0.
- func=001000 (JR) -> id=000001, wrb=00; then func=001001 (JALR) -> id=110001, wrb=10; then func=101010 -> id=010000, wrb=10.
- opcode=100011 (LW) -> exe=1001, mem=010110, wrb=11. opcode=101001 (SH) -> exe=1001, mem=100010, wrb=00. opcode=100100 (LBU) -> mem=011000.
- opcode=000011 (JAL) -> id=100010, wrb=10. opcode=000101 (BNE) -> id=000100, exe=0111, wrb=00.
- opcode=001111 (LUI) -> exe=1101, wrb=10. opcode=111111 -> all fields 0, illegal=1.
- opcode=100011 with i_flush=1 (or i_valid=0) -> all-zero bundle next cycle. Removing the flush restores the LW bundle one edge later.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the reduced-MIPS main decoder: opcodes, funcs,
// ALU and memory-size codes, and bit positions of every control field.
package mips_ctrl_pkg;

    localparam int NB_OPCODE   = 6;
    localparam int NB_FUNC     = 6;
    localparam int NB_ID_CTRL  = 6;
    localparam int NB_EXE_CTRL = 4;
    localparam int NB_MEM_CTRL = 6;
    localparam int NB_WRB_CTRL = 2;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_LHU   = 6'b100101;
    localparam logic [5:0] OP_LWU   = 6'b100111;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_JALR = 6'b001001;

    localparam logic [2:0] ALU_FUNC = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_LUI  = 3'b101;
    localparam logic [2:0] ALU_SLT  = 3'b110;
    localparam logic [2:0] ALU_SUB  = 3'b111;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b11;

    localparam int ID_LINK     = 5;
    localparam int ID_REG_DST  = 4;
    localparam int ID_BEQ      = 3;
    localparam int ID_BNE      = 2;
    localparam int ID_JUMP_IMM = 1;
    localparam int ID_JUMP_REG = 0;

    localparam int EXE_ALU_SRC_IMM = 3;

    localparam int MEM_WRITE    = 5;
    localparam int MEM_READ     = 4;
    localparam int MEM_UNSIGNED = 3;
    localparam int MEM_SIZE_LSB = 1;

    localparam int WRB_REG_WRITE  = 1;
    localparam int WRB_MEM_TO_REG = 0;

    typedef struct packed {
        logic [NB_ID_CTRL-1:0]  id;
        logic [NB_EXE_CTRL-1:0] exe;
        logic [NB_MEM_CTRL-1:0] mem;
        logic [NB_WRB_CTRL-1:0] wrb;
        logic                   illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    function automatic logic [NB_MEM_CTRL-1:0] mem_ctrl(
        input logic       wr,
        input logic       rd,
        input logic       uns,
        input logic [1:0] size
    );
        return {wr, rd, uns, size, 1'b0};
    endfunction

endpackage

// File: rtl/mips_control_unit_decoder.sv
// Combinational opcode/func to per-stage control map; unknown opcodes
// decode to an all-zero bundle with the illegal flag set.
module mips_main_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [NB_OPCODE-1:0] i_opcode,
    input  logic [NB_FUNC-1:0]   i_func,
    output ctrl_t                o_ctrl
);

    always_comb begin
        o_ctrl = CTRL_NOP;
        case (i_opcode)
            OP_RTYPE: begin
                o_ctrl.id[ID_REG_DST]     = 1'b1;
                o_ctrl.wrb[WRB_REG_WRITE] = 1'b1;
                if (i_func == FN_JR) begin
                    o_ctrl.id[ID_REG_DST]     = 1'b0;
                    o_ctrl.id[ID_JUMP_REG]    = 1'b1;
                    o_ctrl.wrb[WRB_REG_WRITE] = 1'b0;
                end else if (i_func == FN_JALR) begin
                    o_ctrl.id[ID_JUMP_REG] = 1'b1;
                    o_ctrl.id[ID_LINK]     = 1'b1;
                end
            end
            OP_J: o_ctrl.id[ID_JUMP_IMM] = 1'b1;
            OP_JAL: begin
                // reg_dst_rd stays 0 so link writes $31
                o_ctrl.id[ID_JUMP_IMM]    = 1'b1;
                o_ctrl.id[ID_LINK]        = 1'b1;
                o_ctrl.wrb[WRB_REG_WRITE] = 1'b1;
            end
            OP_BEQ: begin
                o_ctrl.id[ID_BEQ] = 1'b1;
                o_ctrl.exe        = {1'b0, ALU_SUB};
            end
            OP_BNE: begin
                o_ctrl.id[ID_BNE] = 1'b1;
                o_ctrl.exe        = {1'b0, ALU_SUB};
            end
            OP_ADDI, OP_SLTI, OP_ANDI,
            OP_ORI, OP_XORI, OP_LUI: begin
                o_ctrl.wrb[WRB_REG_WRITE] = 1'b1;
                case (i_opcode)
                    OP_ADDI: o_ctrl.exe = {1'b1, ALU_ADD};
                    OP_SLTI: o_ctrl.exe = {1'b1, ALU_SLT};
                    OP_ANDI: o_ctrl.exe = {1'b1, ALU_AND};
                    OP_ORI:  o_ctrl.exe = {1'b1, ALU_OR};
                    OP_XORI: o_ctrl.exe = {1'b1, ALU_XOR};
                    default: o_ctrl.exe = {1'b1, ALU_LUI};
                endcase
            end
            OP_LB, OP_LH, OP_LW,
            OP_LBU, OP_LHU, OP_LWU: begin
                o_ctrl.exe = {1'b1, ALU_ADD};
                o_ctrl.wrb = 2'b11;
                case (i_opcode)
                    OP_LB:   o_ctrl.mem = mem_ctrl(1'b0, 1'b1, 1'b0, SZ_BYTE);
                    OP_LH:   o_ctrl.mem = mem_ctrl(1'b0, 1'b1, 1'b0, SZ_HALF);
                    OP_LW:   o_ctrl.mem = mem_ctrl(1'b0, 1'b1, 1'b0, SZ_WORD);
                    OP_LBU:  o_ctrl.mem = mem_ctrl(1'b0, 1'b1, 1'b1, SZ_BYTE);
                    OP_LHU:  o_ctrl.mem = mem_ctrl(1'b0, 1'b1, 1'b1, SZ_HALF);
                    default: o_ctrl.mem = mem_ctrl(1'b0, 1'b1, 1'b1, SZ_WORD);
                endcase
            end
            OP_SB: begin
                o_ctrl.exe = {1'b1, ALU_ADD};
                o_ctrl.mem = mem_ctrl(1'b1, 1'b0, 1'b0, SZ_BYTE);
            end
            OP_SH: begin
                o_ctrl.exe = {1'b1, ALU_ADD};
                o_ctrl.mem = mem_ctrl(1'b1, 1'b0, 1'b0, SZ_HALF);
            end
            OP_SW: begin
                o_ctrl.exe = {1'b1, ALU_ADD};
                o_ctrl.mem = mem_ctrl(1'b1, 1'b0, 1'b0, SZ_WORD);
            end
            default: o_ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_control_unit.sv
// ID-stage main control: decode, bubble insertion on flush/invalid,
// and the ID/EX control register.
module mips_control_unit
    import mips_ctrl_pkg::*;
(
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_valid,
    input  logic                   i_flush,
    input  logic [NB_OPCODE-1:0]   i_opcode,
    input  logic [NB_FUNC-1:0]     i_func,
    output logic [NB_ID_CTRL-1:0]  o_id_ctrl,
    output logic [NB_EXE_CTRL-1:0] o_exe_ctrl,
    output logic [NB_MEM_CTRL-1:0] o_mem_ctrl,
    output logic [NB_WRB_CTRL-1:0] o_wrb_ctrl,
    output logic                   o_illegal
);

    ctrl_t dec_ctrl;
    ctrl_t ctrl_d;
    ctrl_t ctrl_q;

    mips_main_decoder u_dec (
        .i_opcode (i_opcode),
        .i_func   (i_func),
        .o_ctrl   (dec_ctrl)
    );

    always_comb begin
        ctrl_d = dec_ctrl;
        if (i_flush || !i_valid) begin
            ctrl_d = CTRL_NOP;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            ctrl_q <= CTRL_NOP;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign o_id_ctrl  = ctrl_q.id;
    assign o_exe_ctrl = ctrl_q.exe;
    assign o_mem_ctrl = ctrl_q.mem;
    assign o_wrb_ctrl = ctrl_q.wrb;
    assign o_illegal  = ctrl_q.illegal;

endmodule

// File: tb/tb_mips_control_unit.sv
// Directed, table-driven bench for mips_control_unit with hand-computed
// expected bundles, plus reset and flush sequences.
module tb_mips_control_unit;

    typedef struct {
        string      name;
        logic       flush;
        logic       valid;
        logic [5:0] op;
        logic [5:0] fn;
        logic [5:0] id;
        logic [3:0] exe;
        logic [5:0] mem;
        logic [1:0] wrb;
        logic       ill;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic       flush;
    logic [5:0] opcode;
    logic [5:0] func;
    logic [5:0] id_ctrl;
    logic [3:0] exe_ctrl;
    logic [5:0] mem_ctrl;
    logic [1:0] wrb_ctrl;
    logic       illegal;

    int checks = 0;
    int errors = 0;
    vec_t tbl[$];

    mips_control_unit dut (
        .i_clock    (clk),
        .i_reset    (rst),
        .i_valid    (valid),
        .i_flush    (flush),
        .i_opcode   (opcode),
        .i_func     (func),
        .o_id_ctrl  (id_ctrl),
        .o_exe_ctrl (exe_ctrl),
        .o_mem_ctrl (mem_ctrl),
        .o_wrb_ctrl (wrb_ctrl),
        .o_illegal  (illegal)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(
        input string nm, input logic fl, input logic va,
        input logic [5:0] op, input logic [5:0] fn,
        input logic [5:0] id, input logic [3:0] exe,
        input logic [5:0] mem, input logic [1:0] wrb,
        input logic ill
    );
        vec_t v;
        v.name = nm; v.flush = fl; v.valid = va;
        v.op = op; v.fn = fn; v.id = id; v.exe = exe;
        v.mem = mem; v.wrb = wrb; v.ill = ill;
        return v;
    endfunction

    task automatic check(
        input string nm, input logic [5:0] id, input logic [3:0] exe,
        input logic [5:0] mem, input logic [1:0] wrb, input logic ill
    );
        logic [18:0] act;
        logic [18:0] exp;
        act = {id_ctrl, exe_ctrl, mem_ctrl, wrb_ctrl, illegal};
        exp = {id, exe, mem, wrb, ill};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got id=%b exe=%b mem=%b wrb=%b ill=%b, want id=%b exe=%b mem=%b wrb=%b ill=%b",
                nm, id_ctrl, exe_ctrl, mem_ctrl, wrb_ctrl, illegal,
                id, exe, mem, wrb, ill);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        flush = v.flush; valid = v.valid;
        opcode = v.op; func = v.fn;
        @(posedge clk);
        #1;
        check(v.name, v.id, v.exe, v.mem, v.wrb, v.ill);
    endtask

    initial begin
        tbl.push_back(mk("rtype0", 0, 1, 6'b000000, 6'b000000,
            6'b010000, 4'b0000, 6'b000000, 2'b10, 0));
        tbl.push_back(mk("jr", 0, 1, 6'b000000, 6'b001000,
            6'b000001, 4'b0000, 6'b000000, 2'b00, 0));
        tbl.push_back(mk("jalr", 0, 1, 6'b000000, 6'b001001,
            6'b110001, 4'b0000, 6'b000000, 2'b10, 0));
        tbl.push_back(mk("slt", 0, 1, 6'b000000, 6'b101010,
            6'b010000, 4'b0000, 6'b000000, 2'b10, 0));
        tbl.push_back(mk("j", 0, 1, 6'b000010, 6'b001001,
            6'b000010, 4'b0000, 6'b000000, 2'b00, 0));
        tbl.push_back(mk("jal", 0, 1, 6'b000011, 6'b000000,
            6'b100010, 4'b0000, 6'b000000, 2'b10, 0));
        tbl.push_back(mk("beq", 0, 1, 6'b000100, 6'b000000,
            6'b001000, 4'b0111, 6'b000000, 2'b00, 0));
        tbl.push_back(mk("bne", 0, 1, 6'b000101, 6'b000000,
            6'b000100, 4'b0111, 6'b000000, 2'b00, 0));
        tbl.push_back(mk("addi", 0, 1, 6'b001000, 6'b001000,
            6'b000000, 4'b1001, 6'b000000, 2'b10, 0));
        tbl.push_back(mk("slti", 0, 1, 6'b001010, 6'b000000,
            6'b000000, 4'b1110, 6'b000000, 2'b10, 0));
        tbl.push_back(mk("andi", 0, 1, 6'b001100, 6'b000000,
            6'b000000, 4'b1010, 6'b000000, 2'b10, 0));
        tbl.push_back(mk("ori", 0, 1, 6'b001101, 6'b000000,
            6'b000000, 4'b1011, 6'b000000, 2'b10, 0));
        tbl.push_back(mk("xori", 0, 1, 6'b001110, 6'b000000,
            6'b000000, 4'b1100, 6'b000000, 2'b10, 0));
        tbl.push_back(mk("lui", 0, 1, 6'b001111, 6'b000000,
            6'b000000, 4'b1101, 6'b000000, 2'b10, 0));
        tbl.push_back(mk("lb", 0, 1, 6'b100000, 6'b000000,
            6'b000000, 4'b1001, 6'b010000, 2'b11, 0));
        tbl.push_back(mk("lh", 0, 1, 6'b100001, 6'b000000,
            6'b000000, 4'b1001, 6'b010010, 2'b11, 0));
        tbl.push_back(mk("lw", 0, 1, 6'b100011, 6'b000000,
            6'b000000, 4'b1001, 6'b010110, 2'b11, 0));
        tbl.push_back(mk("lbu", 0, 1, 6'b100100, 6'b000000,
            6'b000000, 4'b1001, 6'b011000, 2'b11, 0));
        tbl.push_back(mk("lhu", 0, 1, 6'b100101, 6'b000000,
            6'b000000, 4'b1001, 6'b011010, 2'b11, 0));
        tbl.push_back(mk("lwu", 0, 1, 6'b100111, 6'b000000,
            6'b000000, 4'b1001, 6'b011110, 2'b11, 0));
        tbl.push_back(mk("sb", 0, 1, 6'b101000, 6'b000000,
            6'b000000, 4'b1001, 6'b100000, 2'b00, 0));
        tbl.push_back(mk("sh", 0, 1, 6'b101001, 6'b000000,
            6'b000000, 4'b1001, 6'b100010, 2'b00, 0));
        tbl.push_back(mk("sw", 0, 1, 6'b101011, 6'b000000,
            6'b000000, 4'b1001, 6'b100110, 2'b00, 0));
        tbl.push_back(mk("ill_3f", 0, 1, 6'b111111, 6'b000000,
            6'b000000, 4'b0000, 6'b000000, 2'b00, 1));
        tbl.push_back(mk("ill_01", 0, 1, 6'b000001, 6'b001000,
            6'b000000, 4'b0000, 6'b000000, 2'b00, 1));
        tbl.push_back(mk("lw_flush", 1, 1, 6'b100011, 6'b000000,
            6'b000000, 4'b0000, 6'b000000, 2'b00, 0));
        tbl.push_back(mk("lw_restore", 0, 1, 6'b100011, 6'b000000,
            6'b000000, 4'b1001, 6'b010110, 2'b11, 0));
        tbl.push_back(mk("lw_invalid", 0, 0, 6'b100011, 6'b000000,
            6'b000000, 4'b0000, 6'b000000, 2'b00, 0));
        tbl.push_back(mk("ill_flush", 1, 0, 6'b111111, 6'b000000,
            6'b000000, 4'b0000, 6'b000000, 2'b00, 0));
        tbl.push_back(mk("ill_inv", 0, 0, 6'b111110, 6'b000000,
            6'b000000, 4'b0000, 6'b000000, 2'b00, 0));
        tbl.push_back(mk("flush_pri", 1, 1, 6'b001111, 6'b000000,
            6'b000000, 4'b0000, 6'b000000, 2'b00, 0));
        tbl.push_back(mk("ori_back", 0, 1, 6'b001101, 6'b000000,
            6'b000000, 4'b1011, 6'b000000, 2'b10, 0));

        // Load a non-zero bundle, then hit it with reset mid-cycle
        rst = 1'b1; valid = 1'b0; flush = 1'b0;
        opcode = 6'b0; func = 6'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", 6'b0, 4'b0, 6'b0, 2'b0, 0);
        @(negedge clk);
        rst = 1'b0;
        valid = 1'b1; opcode = 6'b100011;
        @(posedge clk);
        #1;
        check("pre_reset_lw", 6'b0, 4'b1001, 6'b010110, 2'b11, 0);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", 6'b0, 4'b0, 6'b0, 2'b0, 0);
        @(posedge clk);
        #1;
        check("reset_edge", 6'b0, 4'b0, 6'b0, 2'b0, 0);
        @(negedge clk);
        opcode = 6'b000000; func = 6'b000000;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset", 6'b010000, 4'b0, 6'b0, 2'b10, 0);

        foreach (tbl[i]) apply(tbl[i]);

        // Illegal flag must drop once a legal op follows
        apply(mk("ill_again", 0, 1, 6'b110000, 6'b000000,
            6'b000000, 4'b0000, 6'b000000, 2'b00, 1));
        apply(mk("legal_after", 0, 1, 6'b000100, 6'b000000,
            6'b001000, 4'b0111, 6'b000000, 2'b00, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
